nv_nvdla_mcif_rd_wrr_arb: RTL and testbench

- Read-request arbiter between the DMA read clients and the MCIF read egress.
- Directly consumes the register-block outputs: per-client 8-bit read weights and the read outstanding count.
- Performs weighted round-robin (WRR) arbitration across NCLIENT clients and throttles issue to the programmed outstanding limit.
- Drives one registered request stream downstream.

---
 rtl/nv_nvdla_mcif_arb_pkg.sv | 11 +
 rtl/nv_nvdla_mcif_rr_pick.sv | 25 ++
 rtl/nv_nvdla_mcif_rd_wrr_arb.sv | 116 +++++++++++
 tb/tb_nv_nvdla_mcif_rd_wrr_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_mcif_arb_pkg.sv
// nv_nvdla_mcif_arb_pkg: shared widths, client-id type and WRR credit-load helper for the MCIF arbiters
package nv_nvdla_mcif_arb_pkg;
   localparam int WT_W  = 8;
   localparam int OS_W  = 9;
   localparam int CID_W = 2;
   typedef logic [CID_W-1:0] cli_id_t;
   // A programmed weight of 0 still earns one grant per round.
   function automatic logic [WT_W-1:0] wrr_load(input logic [WT_W-1:0] w);
      return (w == '0) ? WT_W'(1) : w;
   endfunction
endpackage

// File: rtl/nv_nvdla_mcif_rr_pick.sv
// nv_nvdla_mcif_rr_pick: combinational rotating first-one finder starting at ptr
// Ports: req (per-client request), ptr (search start), vld (any request), idx (first requester at or after ptr)
module nv_nvdla_mcif_rr_pick
   import nv_nvdla_mcif_arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           vld,
   output logic [IDW-1:0] idx
);
   logic [IDW-1:0] c;
   // Scan from farthest to nearest so the closest requester to ptr is written last.
   always_comb begin
      vld = |req;
      idx = ptr;
      c   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         c = IDW'((int'(ptr) + k) % N);
         if (req[c]) idx = c;
      end
   end
endmodule

// File: rtl/nv_nvdla_mcif_rd_wrr_arb.sv
// nv_nvdla_mcif_rd_wrr_arb: weighted round-robin read-request arbiter with outstanding-read throttle
// Ports: cli_req_* (client valid/ready/payload), reg2dp_rd_weight / reg2dp_rd_os_cnt (register config),
//        arb_req_* (registered downstream request), rd_rsp_done (completion pulse), os_underflow (sticky error).
// Optional: NV_NVDLA_MCIF_RD_ARB_PERF_EN adds perf_os_stall, a saturating count of cycles blocked by the OS limit.
module nv_nvdla_mcif_rd_wrr_arb
   import nv_nvdla_mcif_arb_pkg::*;
#(
   parameter int NCLIENT = 4,
   parameter int PW      = 79,
   parameter int IDW     = 2
) (
   input  logic                    nvdla_core_clk,
   input  logic                    nvdla_core_rst,
   input  logic [NCLIENT-1:0]      cli_req_valid,
   output logic [NCLIENT-1:0]      cli_req_ready,
   input  logic [NCLIENT*PW-1:0]   cli_req_pd,
   input  logic [NCLIENT*WT_W-1:0] reg2dp_rd_weight,
   input  logic [7:0]              reg2dp_rd_os_cnt,
   output logic                    arb_req_valid,
   input  logic                    arb_req_ready,
   output logic [PW-1:0]           arb_req_pd,
   output logic [IDW-1:0]          arb_req_id,
   input  logic                    rd_rsp_done,
`ifdef NV_NVDLA_MCIF_RD_ARB_PERF_EN
   output logic [31:0]             perf_os_stall,
`endif
   output logic                    os_underflow
);
   logic [IDW-1:0]  ptr, gnt, ptr_nxt, gnt_nxt;
   logic [WT_W-1:0] credit, w_gnt, w_gnt_nxt, w_ptr_nxt;
   logic [OS_W-1:0] os_cur;
   logic            gnt_vld, load_ok, os_ok, issue_ok, hs;

   function automatic logic [IDW-1:0] inc(input logic [IDW-1:0] i);
      return (i == IDW'(NCLIENT - 1)) ? '0 : i + 1'b1;
   endfunction

   nv_nvdla_mcif_rr_pick #(.N(NCLIENT), .IDW(IDW)) u_pick (
      .req (cli_req_valid),
      .ptr (ptr),
      .vld (gnt_vld),
      .idx (gnt)
   );

   assign ptr_nxt       = inc(ptr);
   assign gnt_nxt       = inc(gnt);
   assign w_gnt         = reg2dp_rd_weight[gnt*WT_W +: WT_W];
   assign w_gnt_nxt     = reg2dp_rd_weight[gnt_nxt*WT_W +: WT_W];
   assign w_ptr_nxt     = reg2dp_rd_weight[ptr_nxt*WT_W +: WT_W];
   assign load_ok       = ~arb_req_valid | arb_req_ready;
   assign os_ok         = os_cur <= {1'b0, reg2dp_rd_os_cnt};
   assign issue_ok      = load_ok & os_ok;
   assign hs            = gnt_vld & issue_ok;
   assign cli_req_ready = hs ? (NCLIENT'(1) << gnt) : '0;

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         arb_req_valid <= 1'b0;
         arb_req_pd    <= '0;
         arb_req_id    <= '0;
      end else if (load_ok) begin
         arb_req_valid <= hs;
         if (hs) begin
            arb_req_pd <= cli_req_pd[gnt*PW +: PW];
            arb_req_id <= gnt;
         end
      end
   end

   // A grant to an idle-pointer neighbour spends one credit of that client's weight;
   // if that exhausts it, the pointer moves straight past it.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         ptr    <= '0;
         credit <= wrr_load(reg2dp_rd_weight[WT_W-1:0]);
      end else if (hs) begin
         if (gnt == ptr) begin
            if (credit > 8'd1) begin
               credit <= credit - 1'b1;
            end else begin
               ptr    <= ptr_nxt;
               credit <= wrr_load(w_ptr_nxt);
            end
         end else if (w_gnt > 8'd1) begin
            ptr    <= gnt;
            credit <= w_gnt - 1'b1;
         end else begin
            ptr    <= gnt_nxt;
            credit <= wrr_load(w_gnt_nxt);
         end
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         os_cur       <= '0;
         os_underflow <= 1'b0;
      end else begin
         if (hs & ~rd_rsp_done & (os_cur != 9'd256))
            os_cur <= os_cur + 1'b1;
         else if (~hs & rd_rsp_done & (os_cur != '0))
            os_cur <= os_cur - 1'b1;
         if (~hs & rd_rsp_done & (os_cur == '0))
            os_underflow <= 1'b1;
      end
   end

`ifdef NV_NVDLA_MCIF_RD_ARB_PERF_EN
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst)
         perf_os_stall <= '0;
      else if ((|cli_req_valid) & load_ok & ~os_ok & ~(&perf_os_stall))
         perf_os_stall <= perf_os_stall + 1'b1;
   end
`endif
endmodule

// File: tb/tb_nv_nvdla_mcif_rd_wrr_arb.sv
// tb_nv_nvdla_mcif_rd_wrr_arb: scoreboard bench with a behavioural WRR/outstanding model
module tb_nv_nvdla_mcif_rd_wrr_arb;
   localparam int NCLIENT = 4;
   localparam int PW      = 79;
   localparam int IDW     = 2;

   logic                  nvdla_core_clk = 1'b0;
   logic                  nvdla_core_rst = 1'b1;
   logic [NCLIENT-1:0]    cli_req_valid = '0;
   logic [NCLIENT-1:0]    cli_req_ready;
   logic [NCLIENT*PW-1:0] cli_req_pd = '0;
   logic [NCLIENT*8-1:0]  reg2dp_rd_weight = '0;
   logic [7:0]            reg2dp_rd_os_cnt = 8'd255;
   logic                  arb_req_valid;
   logic                  arb_req_ready = 1'b1;
   logic [PW-1:0]         arb_req_pd;
   logic [IDW-1:0]        arb_req_id;
   logic                  rd_rsp_done = 1'b0;
   logic                  os_underflow;
`ifdef NV_NVDLA_MCIF_RD_ARB_PERF_EN
   logic [31:0]           perf_os_stall;
`endif

   nv_nvdla_mcif_rd_wrr_arb #(.NCLIENT(NCLIENT), .PW(PW), .IDW(IDW)) dut (
      .nvdla_core_clk   (nvdla_core_clk),
      .nvdla_core_rst   (nvdla_core_rst),
      .cli_req_valid    (cli_req_valid),
      .cli_req_ready    (cli_req_ready),
      .cli_req_pd       (cli_req_pd),
      .reg2dp_rd_weight (reg2dp_rd_weight),
      .reg2dp_rd_os_cnt (reg2dp_rd_os_cnt),
      .arb_req_valid    (arb_req_valid),
      .arb_req_ready    (arb_req_ready),
      .arb_req_pd       (arb_req_pd),
      .arb_req_id       (arb_req_id),
      .rd_rsp_done      (rd_rsp_done),
`ifdef NV_NVDLA_MCIF_RD_ARB_PERF_EN
      .perf_os_stall    (perf_os_stall),
`endif
      .os_underflow     (os_underflow)
   );

   always #5 nvdla_core_clk = ~nvdla_core_clk;

   typedef struct {
      logic [PW-1:0] pd;
      int            id;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_bad = 0;
   int   dut_hs_cnt = 0;
   int   m_ptr = 0, m_credit = 1, m_os = 0;
   bit   m_valid = 0, m_uf = 0, log_en = 0;
   int   glog[$];

   function automatic void chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic int ld(int x);
      return (x == 0) ? 1 : x;
   endfunction

   // Reference model: WRR rules and outstanding accounting in plain integers.
   always @(negedge nvdla_core_clk) begin
      int w[NCLIENT];
      int g, idx;
      bit hs;
      logic [NCLIENT-1:0] er;
      for (int i = 0; i < NCLIENT; i++) w[i] = int'(reg2dp_rd_weight[i*8 +: 8]);
      if (nvdla_core_rst) begin
         m_ptr = 0; m_credit = ld(w[0]); m_os = 0; m_uf = 0; m_valid = 0;
         q.delete();
      end else begin
         g = -1;
         for (int k = 0; k < NCLIENT; k++) begin
            idx = (m_ptr + k) % NCLIENT;
            if (g < 0 && cli_req_valid[IDW'(idx)]) g = idx;
         end
         hs = (g >= 0) && (!m_valid || arb_req_ready) && (m_os <= int'(reg2dp_rd_os_cnt));
         er = hs ? (NCLIENT'(1) << g) : '0;
         chk("cli_req_ready", PW'(cli_req_ready), PW'(er));
         chk("arb_req_valid", PW'(arb_req_valid), PW'(m_valid));
         chk("os_underflow", PW'(os_underflow), PW'(m_uf));
         chk("os_cur", PW'(dut.os_cur), PW'(m_os));
         chk("ptr", PW'(dut.ptr), PW'(m_ptr));
         chk("credit", PW'(dut.credit), PW'(m_credit));
         if (!m_valid || arb_req_ready) m_valid = hs;
         if (hs) begin
            q.push_back('{pd: cli_req_pd[g*PW +: PW], id: g});
            if (log_en) glog.push_back(g);
            if (g == m_ptr) begin
               if (m_credit > 1) m_credit--;
               else begin m_ptr = (m_ptr + 1) % NCLIENT; m_credit = ld(w[m_ptr]); end
            end else if (w[g] > 1) begin
               m_ptr = g; m_credit = w[g] - 1;
            end else begin
               m_ptr = (g + 1) % NCLIENT; m_credit = ld(w[m_ptr]);
            end
         end
         if (hs && !rd_rsp_done) m_os = (m_os == 256) ? 256 : m_os + 1;
         else if (!hs && rd_rsp_done) begin
            if (m_os == 0) m_uf = 1;
            else m_os--;
         end
      end
   end

   // Monitor: output stage must always show the oldest expected request.
   always @(negedge nvdla_core_clk) begin
      if (!nvdla_core_rst) begin
         if (|(cli_req_valid & cli_req_ready)) dut_hs_cnt++;
         if (arb_req_valid) begin
            if (q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL out_unexpected: got valid id=%0d expected no request", arb_req_id);
            end else begin
               chk("arb_req_pd", arb_req_pd, q[0].pd);
               chk("arb_req_id", PW'(arb_req_id), PW'(q[0].id));
               if (arb_req_ready) void'(q.pop_front());
            end
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge nvdla_core_clk);
         #1;
      end
   endtask

   task automatic rand_pd();
      logic [319:0] t;
      for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
      cli_req_pd = t[NCLIENT*PW-1:0];
   endtask

   task automatic set_w(int a, int b, int c, int d);
      reg2dp_rd_weight = {8'(d), 8'(c), 8'(b), 8'(a)};
   endtask

   task automatic do_reset();
      nvdla_core_rst = 1'b1;
      cyc(2);
      nvdla_core_rst = 1'b0;
   endtask

   int base;
   int pat[10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};

   initial begin
      set_w(1, 2, 3, 4);
      rand_pd();
      cyc(2);
      chk("rst_valid", PW'(arb_req_valid), '0);
      chk("rst_pd", arb_req_pd, '0);
      chk("rst_id", PW'(arb_req_id), '0);
      chk("rst_uf", PW'(os_underflow), '0);
      chk("rst_credit", PW'(dut.credit), PW'(1));
      nvdla_core_rst = 1'b0;

      // WRR sequence with weights 1,2,3,4
      reg2dp_rd_os_cnt = 8'd255;
      cli_req_valid = '1;
      log_en = 1;
      for (int i = 0; i < 40; i++) begin
         rand_pd();
         rd_rsp_done = 1'($urandom_range(0, 1));
         cyc(1);
      end
      log_en = 0;
      rd_rsp_done = 0;
      chk("wrr_len", PW'(glog.size()), PW'(40));
      for (int i = 0; i < 40 && i < glog.size(); i++) chk("wrr_seq", PW'(glog[i]), PW'(pat[i % 10]));

      // Outstanding limit of 2 in flight
      do_reset();
      reg2dp_rd_os_cnt = 8'd1;
      cli_req_valid = '1;
      base = dut_hs_cnt;
      cyc(6);
      chk("os_limit_issues", PW'(dut_hs_cnt - base), PW'(2));
      chk("os_limit_ready", PW'(cli_req_ready), '0);
      rd_rsp_done = 1;
      cyc(1);
      rd_rsp_done = 0;
      cyc(4);
      chk("os_after_done", PW'(dut_hs_cnt - base), PW'(3));

      // Issue and completion in the same cycle
      reg2dp_rd_os_cnt = 8'd5;
      rd_rsp_done = 1;
      cyc(1);
      rd_rsp_done = 0;
      cli_req_valid = '0;
      chk("os_same_cycle", PW'(dut.os_cur), PW'(2));
      chk("uf_same_cycle", PW'(os_underflow), '0);

      // Downstream back-pressure
      cli_req_valid = '1;
      rand_pd();
      cyc(1);
      arb_req_ready = 0;
      for (int i = 0; i < 5; i++) begin
         rand_pd();
         cyc(1);
      end
      chk("bp_os", PW'(dut.os_cur), PW'(3));
      arb_req_ready = 1;
      cli_req_valid = '0;
      cyc(2);

      // Single requester, all weights zero
      do_reset();
      set_w(0, 0, 0, 0);
      cyc(1);
      reg2dp_rd_os_cnt = 8'd255;
      cli_req_valid = 4'b0100;
      base = dut_hs_cnt;
      cyc(8);
      chk("single_rate", PW'(dut_hs_cnt - base), PW'(8));
      chk("single_ptr", PW'(dut.ptr), PW'(3));
      cli_req_valid = '0;
      cyc(2);

      // Underflow is sticky until reset
      do_reset();
      rd_rsp_done = 1;
      cyc(1);
      rd_rsp_done = 0;
      chk("uf_set", PW'(os_underflow), PW'(1));
      cyc(3);
      chk("uf_hold", PW'(os_underflow), PW'(1));
      do_reset();
      chk("uf_clear", PW'(os_underflow), '0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) begin
            set_w($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
            reg2dp_rd_os_cnt = 8'($urandom_range(0, 4));
         end
         cli_req_valid = NCLIENT'($urandom);
         arb_req_ready = ($urandom_range(0, 9) < 7);
         rd_rsp_done = ($urandom_range(0, 9) < 3);
         nvdla_core_rst = ($urandom_range(0, 499) == 0);
         rand_pd();
         cyc(1);
      end
      nvdla_core_rst = 0;
      cli_req_valid = '0;
      rd_rsp_done = 0;
      arb_req_ready = 1;
      cyc(3);
      chk("drain", PW'(q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
